// File: rtl/liteeth_sram_fifo_ctrl_if.sv
// Stream and SRAM-macro signal bundle for liteeth_sram_fifo_ctrl.
// The master modport is the controller; the slave modport is its environment (pusher, popper, macro).
interface liteeth_sram_fifo_ctrl_if #(
  parameter int BITS       = 64,
  parameter int ADDR_WIDTH = 6
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [BITS-1:0]       wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [BITS-1:0]       rd_data;
  logic [ADDR_WIDTH+1:0] level;
  logic                  rw0_ce_in;
  logic                  rw0_we_in;
  logic [ADDR_WIDTH-1:0] rw0_addr_in;
  logic [BITS-1:0]       rw0_wd_in;
  logic                  r0_ce_in;
  logic [ADDR_WIDTH-1:0] r0_addr_in;
  logic [BITS-1:0]       r0_rd_out;

  modport master (
    input  wr_valid, wr_data, rd_ready, r0_rd_out,
    output wr_ready, rd_valid, rd_data, level,
           rw0_ce_in, rw0_we_in, rw0_addr_in, rw0_wd_in,
           r0_ce_in, r0_addr_in
  );

  modport slave (
    output wr_valid, wr_data, rd_ready, r0_rd_out,
    input  wr_ready, rd_valid, rd_data, level,
           rw0_ce_in, rw0_we_in, rw0_addr_in, rw0_wd_in,
           r0_ce_in, r0_addr_in
  );
endinterface

// File: rtl/liteeth_sram_fifo_ctrl.sv
// FWFT FIFO controller over a 1rw1r SRAM macro with a two-entry output buffer.
// Optional macro LITEETH_SRAM_FIFO_BYPASS_EN routes pushes straight into the output buffer when the FIFO is drained.
module liteeth_sram_fifo_ctrl #(
  parameter int BITS       = 64,
  parameter int WORD_DEPTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic sys_clk,
  input  logic sys_rst,
  liteeth_sram_fifo_ctrl_if.master bus
);
  localparam int LW = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(WORD_DEPTH);

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   scount;
  logic                  inflight;
  logic [1:0]            ocount;
  logic                  hd;
  logic [BITS-1:0]       obuf [2];

  logic            push;
  logic            pop;
  logic            issue;
  logic            bypass;
  logic            sram_wr;
  logic            buf_wr;
  logic            wslot;
  logic [1:0]      occ;
  logic [BITS-1:0] buf_din;

  assign bus.wr_ready = !sys_rst && (scount < DEPTH_CNT);
  assign bus.rd_valid = (ocount != 2'd0);
  assign bus.rd_data  = obuf[hd];
  assign bus.level    = LW'(scount) + LW'(inflight) + LW'(ocount);

  assign push = bus.wr_valid && bus.wr_ready;
  assign pop  = bus.rd_valid && bus.rd_ready;

  // Buffer slots committed or reserved; a read may only be issued if its return will fit.
  assign occ   = ocount + {1'b0, inflight};
  assign issue = (scount != '0) && ((occ < 2'd2) || ((occ == 2'd2) && pop));

  always_comb begin
    bypass = 1'b0;
`ifdef LITEETH_SRAM_FIFO_BYPASS_EN
    bypass = push && (scount == '0) && !inflight && ((ocount != 2'd2) || pop);
`else
    bypass = 1'b0;
`endif
  end

  assign sram_wr = push && !bypass;
  // Return and bypass are exclusive: bypass requires no read in flight.
  assign buf_wr  = inflight || bypass;
  assign buf_din = inflight ? bus.r0_rd_out : bus.wr_data;
  // Tail slot; with two entries held and a pop, this is the slot being vacated.
  assign wslot   = hd ^ ocount[0];

  assign bus.rw0_ce_in   = sram_wr;
  assign bus.rw0_we_in   = sram_wr;
  assign bus.rw0_addr_in = wptr;
  assign bus.rw0_wd_in   = sram_wr ? bus.wr_data : '0;
  assign bus.r0_ce_in    = issue;
  assign bus.r0_addr_in  = rptr;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wptr     <= '0;
      rptr     <= '0;
      scount   <= '0;
      inflight <= 1'b0;
      ocount   <= 2'd0;
      hd       <= 1'b0;
    end else begin
      if (sram_wr) wptr <= wptr + 1'b1;
      if (issue)   rptr <= rptr + 1'b1;
      case ({sram_wr, issue})
        2'b10:   scount <= scount + 1'b1;
        2'b01:   scount <= scount - 1'b1;
        default: scount <= scount;
      endcase
      inflight <= issue;
      case ({buf_wr, pop})
        2'b10:   ocount <= ocount + 2'd1;
        2'b01:   ocount <= ocount - 2'd1;
        default: ocount <= ocount;
      endcase
      if (pop) hd <= ~hd;
    end
  end

  // Output buffer storage; cleared on reset so rd_data reads zero while empty after reset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      obuf[0] <= '0;
      obuf[1] <= '0;
    end else if (buf_wr) begin
      obuf[wslot] <= buf_din;
    end
  end
endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// Scoreboard bench for liteeth_sram_fifo_ctrl with a behavioural SRAM macro and occupancy model.
module tb_liteeth_sram_fifo_ctrl;
  localparam int BITS = 64;
  localparam int ADDR_WIDTH = 6;
  localparam int DEPTH = 64;
`ifdef LITEETH_SRAM_FIFO_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  liteeth_sram_fifo_ctrl_if #(.BITS(BITS), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  liteeth_sram_fifo_ctrl #(.BITS(BITS), .WORD_DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus(bus)
  );

  // Macro model: write on rw port, registered read data one cycle after r0_ce_in.
  logic [BITS-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.rw0_ce_in && bus.rw0_we_in) mem[bus.rw0_addr_in] <= bus.rw0_wd_in;
    if (bus.r0_ce_in) bus.r0_rd_out <= mem[bus.r0_addr_in];
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [BITS-1:0] exp_q [$];
  int mlevel = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: expected occupancy is words accepted minus words popped.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mlevel = 0;
      chk(!bus.rd_valid && !bus.wr_ready && bus.level == 0 && !bus.rw0_ce_in && !bus.rw0_we_in &&
          !bus.r0_ce_in && bus.rw0_addr_in == 0 && bus.r0_addr_in == 0,
          "reset_ctrl", {bus.rd_valid, bus.wr_ready, bus.rw0_ce_in, bus.r0_ce_in, bus.level}, 64'h0);
      chk(bus.rd_data == 0 && bus.rw0_wd_in == 0, "reset_data", bus.rd_data, 64'h0);
    end else begin
      chk(bus.level == mlevel, "level", 64'(bus.level), 64'(mlevel));
      if (mlevel < DEPTH) chk(bus.wr_ready, "wr_ready_room", 64'(bus.wr_ready), 64'h1);
      chk(!bus.rw0_ce_in || (bus.wr_valid && bus.wr_ready), "write_without_push", 64'(bus.rw0_ce_in), 64'h0);
      if (bus.rd_valid && bus.rd_ready) begin
        if (exp_q.size() == 0) chk(1'b0, "pop_empty", bus.rd_data, 64'h0);
        else begin
          logic [BITS-1:0] e;
          e = exp_q.pop_front();
          chk(bus.rd_data == e, "rd_data", bus.rd_data, e);
        end
        mlevel--;
      end
      if (bus.wr_valid && bus.wr_ready) mlevel++;
    end
  end

  task automatic step(input bit wv, input logic [BITS-1:0] d, input bit rr, output bit acc);
    @(posedge clk);
    #1;
    bus.wr_valid = wv;
    bus.wr_data  = d;
    bus.rd_ready = rr;
    #1;
    acc = wv && bus.wr_ready;
    if (acc) exp_q.push_back(d);
  endtask

  task automatic drain(input int budget);
    bit acc;
    int c;
    c = 0;
    while (bus.level != 0 && c < budget) begin
      step(1'b0, '0, 1'b1, acc);
      c++;
    end
    step(1'b0, '0, 1'b1, acc);
    chk(bus.level == 0, "drain_level", 64'(bus.level), 64'h0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int lat, i, cyc, first, last, npop, stall, pushed;
    logic [BITS-1:0] w;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    for (int k = 0; k < 5; k++) begin
      step(1'b0, '0, 1'b0, acc);
      chk(bus.wr_ready && !bus.r0_ce_in && !bus.rw0_ce_in, "idle",
          {bus.wr_ready, bus.r0_ce_in, bus.rw0_ce_in}, 64'h4);
    end

    // Single push latency
    step(1'b1, 64'hDEADBEEF_00000001, 1'b1, acc);
    chk(acc, "single_accept", 64'(acc), 64'h1);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, '0, 1'b1, acc);
      if (bus.rd_valid && lat == 0) begin
        lat = k;
        chk(bus.rd_data == 64'hDEADBEEF_00000001, "single_data", bus.rd_data, 64'hDEADBEEF_00000001);
      end
    end
    chk(lat == LAT, "single_latency", 64'(lat), 64'(LAT));
    chk(bus.level == 0, "single_level", 64'(bus.level), 64'h0);

    // Fill with reader stalled
    i = 0;
    cyc = 0;
    while (i < DEPTH + 2 && cyc < 300) begin
      step(1'b1, 64'(i), 1'b0, acc);
      if (acc) i++;
      cyc++;
    end
    repeat (4) step(1'b0, '0, 1'b0, acc);
    chk(bus.level == DEPTH + 2, "fill_level", 64'(bus.level), 64'(DEPTH + 2));
    chk(!bus.wr_ready, "fill_wr_ready", 64'(bus.wr_ready), 64'h0);
    step(1'b1, 64'h999, 1'b0, acc);
    chk(!acc, "fill_overflow_ignored", 64'(acc), 64'h0);
    step(1'b0, '0, 1'b0, acc);
    chk(bus.level == DEPTH + 2, "fill_level_after_67th", 64'(bus.level), 64'(DEPTH + 2));
    drain(300);

    // Continuous streaming
    pushed = 0; npop = 0; stall = 0; first = -1; last = -1; cyc = 0;
    while ((pushed < 1000 || npop < 1000) && cyc < 3000) begin
      step(pushed < 1000, 64'h5000_0000_0000_0000 + 64'(pushed), 1'b1, acc);
      if (pushed < 1000 && !acc) stall++;
      if (acc) pushed++;
      if (bus.rd_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        npop++;
      end
      cyc++;
    end
    chk(stall == 0, "stream_push_stall", 64'(stall), 64'h0);
    chk(npop == 1000, "stream_pops", 64'(npop), 64'd1000);
    chk(last - first + 1 == 1000, "stream_no_gaps", 64'(last - first + 1), 64'd1000);
    chk(first == LAT, "stream_first_latency", 64'(first), 64'(LAT));
    drain(20);

    // Random traffic
    pushed = 0;
    cyc = 0;
    while (pushed < 10000 && cyc < 60000) begin
      w = {$urandom, $urandom};
      step(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), acc);
      if (acc) pushed++;
      cyc++;
    end
    chk(pushed == 10000, "random_pushed", 64'(pushed), 64'd10000);
    drain(500);
    chk(exp_q.size() == 0, "random_queue_empty", 64'(exp_q.size()), 64'h0);

    // Reset with words held and a read in flight
    i = 0;
    cyc = 0;
    while (i < 10 && cyc < 50) begin
      step(1'b1, 64'hA000 + 64'(i), 1'b0, acc);
      if (acc) i++;
      cyc++;
    end
    repeat (4) step(1'b0, '0, 1'b0, acc);
    step(1'b0, '0, 1'b1, acc);
    chk(bus.r0_ce_in, "issue_before_reset", 64'(bus.r0_ce_in), 64'h1);
    @(posedge clk);
    #1;
    bus.rd_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk(!bus.rd_valid && !bus.wr_ready && bus.level == 0 && bus.rd_data == 0 && !bus.r0_ce_in,
        "reset_immediate", {bus.rd_valid, bus.wr_ready, bus.level}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, acc);
    chk(acc, "post_reset_accept", 64'(acc), 64'h1);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, '0, 1'b1, acc);
      if (bus.rd_valid && lat == 0) begin
        lat = k;
        chk(bus.rd_data == 64'h1234_5678_9ABC_DEF0, "post_reset_first", bus.rd_data, 64'h1234_5678_9ABC_DEF0);
      end
    end
    chk(lat == LAT, "post_reset_latency", 64'(lat), 64'(LAT));
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
